iot_event_sequencer: RTL
========================

Name: iot_event_sequencer

Overview:
- Initiator side of the Active IoT Devices Monitor `change`/`on_off` event interface.
- Accepts a requested active-device count and emits one-cycle device on/off events that move a downstream monitor counter from its current value to the target, one step per event.
- Keeps a shadow copy of the count implied by the events it has issued.
- Used as a stimulus source in system benches and as the device-event front end in the top level.

Parameters:
- WIDTH, 8, width of the device count and target.
- GAP, 0, number of idle cycles (change=0) inserted between consecutive events; legal range 0..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low: sampled on the rising edge of clk; rst=0 resets the block.
- start  input  1  request; sampled only in IDLE.
- target  input  WIDTH  requested active-device count; latched when start is accepted.
- change  output  1  event strobe to the monitor; 1 = apply on_off this cycle.
- on_off  output  1  event direction; 1 = device switched on (+1), 0 = device switched off (-1); meaningful only when change=1.
- count  output  WIDTH  shadow count, equal to the number of on events minus off events issued since reset.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when count equals the latched target.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at an edge): change=0, on_off=0, count=0, busy=0, done=0; state=IDLE; GAP counter=0; latched target=0. This applies in every state, including mid-sequence; no further events are issued after the reset edge.
- States: IDLE, STEP, WAIT, DONE.
- IDLE, start=1 at edge k: latch target into tgt; busy=1 at edge k.
  - tgt==count: go to DONE.
  - Otherwise: go to STEP.
- STEP, one cycle per event:
  - change=1.
  - on_off=1 and count=count+1 if tgt>count; otherwise on_off=0 and count=count-1.
  - Compare tgt against count before the update.
  - After the update: if count==tgt, go to DONE; else go to WAIT if GAP>0, else stay in STEP.
- WAIT: change=0 for exactly GAP cycles, then return to STEP.
- DONE: change=0, done=1 and busy=0 for one cycle, then go to IDLE; done returns to 0.
- Timing: with D=|tgt-count| at acceptance edge k, event i (1..D) is driven in the cycle after edge k+1+(i-1)(GAP+1).
  - done is driven one cycle after the last event.
  - D=0: done appears after edge k+1 and no events are issued.
- Unsigned arithmetic. count never wraps, because every step moves toward tgt, which lies in 0..2^WIDTH-1.
- start while busy=1, or during the DONE cycle, is ignored. The target input is not re-sampled mid-sequence.
- start held high continuously: a new request is accepted in each IDLE cycle, i.e. once every sequence plus one cycle.
- on_off holds its last value when change=0. Consumers must qualify on_off with change.

Optional Feature:
- Macro: IOT_EVENT_SEQ_ABORT_EN.
- Defined: adds input port `abort` (1 bit).
  - abort=1 sampled in STEP or WAIT: go to DONE next edge with no further events; count keeps the value reached.
  - abort has priority over the event that STEP would otherwise issue at that edge.
  - done pulses as normal; the sequence ends with count!=tgt.
  - abort is ignored in IDLE and DONE.
- Undefined: no abort port exists; every accepted sequence runs to count==tgt unless reset.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 and target=5 -> change=0, count=0, busy=0, done=0; no events issued.
- Count up, GAP=0: from count=0, start with target=3 -> change=1/on_off=1 for 3 consecutive cycles; count steps 1,2,3; done pulses 1 cycle after the third event; busy falls with done.
- Count down, GAP=2: from count=3, start with target=1 -> 2 events with on_off=0, separated by exactly 2 cycles of change=0; count steps 2,1; done pulses once.
- Zero distance and ignored start: start with target=count=1 -> no change pulse, done after edge k+1. During a target=6 sequence, pulse start with target=0 -> ignored; final count=6.
- Reset mid-sequence: from count=0, start with target=10; drive rst=0 after 4 events -> next edge count=0, busy=0, change=0; no done pulse.
- With IOT_EVENT_SEQ_ABORT_EN: from count=0, target=8, abort=1 after 3 events -> no 4th event; count=3; single done pulse the next cycle.

Source files
------------

// File: rtl/iot_event_sequencer_if.sv
// Start/target request and change/on_off event bundle for iot_event_sequencer.
// IOT_EVENT_SEQ_ABORT_EN adds the abort request line.
interface iot_event_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] target;
  logic             change;
  logic             on_off;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
`ifdef IOT_EVENT_SEQ_ABORT_EN
  logic             abort;

  modport master (output start, target, abort,
                  input  change, on_off, count, busy, done);
  modport slave  (input  start, target, abort,
                  output change, on_off, count, busy, done);
`else
  modport master (output start, target,
                  input  change, on_off, count, busy, done);
  modport slave  (input  start, target,
                  output change, on_off, count, busy, done);
`endif
endinterface

// File: rtl/iot_event_sequencer.sv
// Emits one-cycle on/off device events stepping a shadow count toward a latched target.
// Optional abort input enabled by defining IOT_EVENT_SEQ_ABORT_EN.
module iot_event_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  iot_event_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT, S_DONE} state_e;

  localparam bit         HasGap  = (GAP > 0);
  localparam logic [7:0] GapLast = HasGap ? 8'(GAP - 1) : 8'd0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [7:0]       gap_q, gap_d;
  logic             change_q, change_d;
  logic             on_off_q, on_off_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             abort_w;
  logic             step_up;
  logic [WIDTH-1:0] step_cnt;

`ifdef IOT_EVENT_SEQ_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  // Direction is decided from the count before this step's update.
  assign step_up  = (tgt_q > count_q);
  assign step_cnt = step_up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      count_q  <= '0;
      gap_q    <= '0;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      change_q <= change_d;
      on_off_q <= on_off_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tgt_d   = bus.target;
          state_d = (bus.target == count_q) ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        if (abort_w || step_cnt == tgt_q) begin
          state_d = S_DONE;
        end else if (HasGap) begin
          state_d = S_WAIT;
          gap_d   = GapLast;
        end
      end
      S_WAIT: begin
        if (abort_w)          state_d = S_DONE;
        else if (gap_q == '0) state_d = S_STEP;
        else                  gap_d   = gap_q - 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    change_d = 1'b0;
    on_off_d = on_off_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.start) busy_d = 1'b1;
      S_STEP: begin
        if (!abort_w) begin
          change_d = 1'b1;
          on_off_d = step_up;
          count_d  = step_cnt;
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.change = change_q;
  assign bus.on_off = on_off_q;
  assign bus.count  = count_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
